// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: fetches one word per request over a req/ready handshake,
// strobes it into the instruction register and maintains the program counter.
module instruction_fetch_unit #(
  parameter int unsigned          INSTRUCTION_LEN = 16,
  parameter int unsigned          ADDR_LEN        = 16,
  parameter logic [ADDR_LEN-1:0]  RESET_PC        = '0,
  parameter int unsigned          TIMEOUT_CYCLES  = 15
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       fetch_req,
  input  logic                       pc_ld_en,
  input  logic [ADDR_LEN-1:0]        pc_ld_value,
  output logic                       mem_req,
  output logic [ADDR_LEN-1:0]        mem_addr,
  input  logic                       mem_ready,
  input  logic [INSTRUCTION_LEN-1:0] mem_rdata,
  output logic                       ir_wr_en,
  output logic [INSTRUCTION_LEN-1:0] instruction_out,
  output logic [ADDR_LEN-1:0]        pc,
  output logic                       busy,
  output logic                       fetch_done,
  output logic                       fetch_err
);

  localparam int unsigned    CntW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StFetch, StWrite} state_e;

  state_e                     state_q, state_d;
  logic [ADDR_LEN-1:0]        fetch_addr_q, fetch_addr_d;
  logic [ADDR_LEN-1:0]        pc_q, pc_d;
  logic [INSTRUCTION_LEN-1:0] data_q, data_d;
  logic [CntW-1:0]            cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      fetch_addr_q <= RESET_PC;
      pc_q         <= RESET_PC;
      data_q       <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      pc_q         <= pc_d;
      data_q       <= data_d;
      cnt_q        <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    fetch_addr_d = fetch_addr_q;
    pc_d         = pc_q;
    data_d       = data_q;
    cnt_d        = cnt_q;
    fetch_err    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (fetch_req) begin
          state_d      = StFetch;
          // A same-cycle branch target is fetched directly rather than the stale PC.
          fetch_addr_d = pc_ld_en ? pc_ld_value : pc_q;
          cnt_d        = '0;
        end
      end
      StFetch: begin
        if (mem_ready) begin
          data_d  = mem_rdata;
          state_d = StWrite;
        end else if (cnt_q == CntLast) begin
          fetch_err = 1'b1;
          state_d   = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWrite: begin
        state_d = StIdle;
        pc_d    = fetch_addr_q + 1'b1;
      end
      default: state_d = StIdle;
    endcase
    // A load wins over the post-fetch increment.
    if (pc_ld_en) pc_d = pc_ld_value;
  end

  assign mem_req         = (state_q == StFetch);
  assign mem_addr        = fetch_addr_q;
  assign ir_wr_en        = (state_q == StWrite);
  assign fetch_done      = (state_q == StWrite);
  assign busy            = (state_q != StIdle);
  assign instruction_out = data_q;
  assign pc              = pc_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: a memory model with configurable
// wait states plus a scoreboard of expected instruction words.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fetch_req = 1'b0;
  logic        pc_ld_en = 1'b0;
  logic [15:0] pc_ld_value = '0;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ready;
  logic [15:0] mem_rdata;
  logic        ir_wr_en;
  logic [15:0] instruction_out;
  logic [15:0] pc;
  logic        busy;
  logic        fetch_done;
  logic        fetch_err;

  int checks = 0;
  int failures = 0;

  logic [15:0] exp_q[$];
  logic [15:0] last_word = '0;

  instruction_fetch_unit dut (
    .clk             (clk),
    .rst             (rst),
    .fetch_req       (fetch_req),
    .pc_ld_en        (pc_ld_en),
    .pc_ld_value     (pc_ld_value),
    .mem_req         (mem_req),
    .mem_addr        (mem_addr),
    .mem_ready       (mem_ready),
    .mem_rdata       (mem_rdata),
    .ir_wr_en        (ir_wr_en),
    .instruction_out (instruction_out),
    .pc              (pc),
    .busy            (busy),
    .fetch_done      (fetch_done),
    .fetch_err       (fetch_err)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] word(input logic [15:0] a);
    return a ^ 16'hA5C3;
  endfunction

  // Memory model: answers after wait_cfg wait cycles unless never_ready.
  int wait_cfg = 0;
  bit never_ready = 1'b0;
  int req_cnt = 0;
  always @(posedge clk or posedge rst) begin
    if (rst) req_cnt <= 0;
    else if (!mem_req || mem_ready) req_cnt <= 0;
    else req_cnt <= req_cnt + 1;
  end
  always_comb begin
    mem_ready = mem_req && !never_ready && (req_cnt == wait_cfg);
    mem_rdata = mem_ready ? word(mem_addr) : 16'hDEAD;
  end

  // Passive monitor; the tests compare its tallies.
  int          req_cycles = 0;
  int          ir_cnt = 0;
  int          err_cnt = 0;
  int          strobe_diff = 0;
  int          req_idle = 0;
  bit          addr_unstable = 1'b0;
  logic [15:0] first_addr = '0;
  always @(negedge clk) begin
    if (mem_req === 1'b1) begin
      if (req_cycles == 0) first_addr = mem_addr;
      else if (mem_addr !== first_addr) addr_unstable = 1'b1;
      req_cycles++;
    end
    if (ir_wr_en === 1'b1) ir_cnt++;
    if (fetch_err === 1'b1) err_cnt++;
    if (ir_wr_en !== fetch_done) strobe_diff++;
    if (mem_req === 1'b1 && busy !== 1'b1) req_idle++;
  end

  task automatic clear_mon();
    req_cycles = 0; ir_cnt = 0; err_cnt = 0; strobe_diff = 0; req_idle = 0;
    addr_unstable = 1'b0;
  endtask

  // Waits (bounded) at negedges for ir_wr_en or fetch_err; n counts negedges seen.
  task automatic wait_event(input bit want_err, output int n, output bit ok);
    ok = 1'b0;
    n = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      n++;
      if ((want_err ? fetch_err : ir_wr_en) === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic pulse_fetch(input logic ld, input logic [15:0] ldv);
    fetch_req = 1'b1; pc_ld_en = ld; pc_ld_value = ldv;
    @(posedge clk); #1;
    fetch_req = 1'b0; pc_ld_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++;
    if ({mem_req, ir_wr_en, fetch_done, fetch_err, busy} !== 5'b0) begin
      failures++;
      $display("FAIL reset_strobes got=%b want=00000",
               {mem_req, ir_wr_en, fetch_done, fetch_err, busy});
    end
    checks++;
    if (instruction_out !== 16'h0 || mem_addr !== 16'h0 || pc !== 16'h0) begin
      failures++;
      $display("FAIL reset_values ir=%h addr=%h pc=%h want 0000", instruction_out, mem_addr, pc);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic test_zero_wait();
    int n; bit ok; logic [15:0] e;
    clear_mon(); wait_cfg = 0;
    exp_q.push_back(word(16'h0000));
    pulse_fetch(1'b0, 16'h0);
    wait_event(1'b0, n, ok);
    checks++;
    if (!ok || n != 2) begin
      failures++; $display("FAIL zw_latency got=%0d ok=%0d want=2", n, ok);
    end
    e = exp_q.size() ? exp_q.pop_front() : 16'hxxxx;
    last_word = e;
    checks++;
    if (instruction_out !== e || e !== 16'hA5C3) begin
      failures++; $display("FAIL zw_data got=%h want=%h", instruction_out, e);
    end
    @(negedge clk); #1;
    checks++;
    if (pc !== 16'h0001 || busy !== 1'b0) begin
      failures++; $display("FAIL zw_pc got=%h busy=%b want=0001 busy=0", pc, busy);
    end
    checks++;
    if (req_cycles != 1 || first_addr !== 16'h0 || ir_cnt != 1 || strobe_diff != 0) begin
      failures++;
      $display("FAIL zw_handshake req=%0d addr=%h ir=%0d sd=%0d want 1/0000/1/0",
               req_cycles, first_addr, ir_cnt, strobe_diff);
    end
  endtask

  task automatic test_wait4();
    int n; bit ok; logic [15:0] e;
    clear_mon(); wait_cfg = 4;
    exp_q.push_back(word(16'h0001));
    pulse_fetch(1'b0, 16'h0);
    wait_event(1'b0, n, ok);
    checks++;
    if (!ok || n != 6) begin
      failures++; $display("FAIL w4_latency got=%0d ok=%0d want=6", n, ok);
    end
    e = exp_q.size() ? exp_q.pop_front() : 16'hxxxx;
    last_word = e;
    checks++;
    if (instruction_out !== e) begin
      failures++; $display("FAIL w4_data got=%h want=%h", instruction_out, e);
    end
    @(negedge clk); #1;
    checks++;
    if (req_cycles != 5 || addr_unstable || first_addr !== 16'h0001 || ir_cnt != 1 ||
        err_cnt != 0 || pc !== 16'h0002) begin
      failures++;
      $display("FAIL w4_handshake req=%0d unst=%0d addr=%h ir=%0d err=%0d pc=%h want 5/0/0001/1/0/0002",
               req_cycles, addr_unstable, first_addr, ir_cnt, err_cnt, pc);
    end
  endtask

  task automatic test_timeout();
    int n; bit ok;
    clear_mon(); never_ready = 1'b1;
    pulse_fetch(1'b0, 16'h0);
    wait_event(1'b1, n, ok);
    checks++;
    if (!ok || n != 15) begin
      failures++; $display("FAIL to_cycle got=%0d ok=%0d want=15", n, ok);
    end
    @(negedge clk); #1;
    never_ready = 1'b0;
    checks++;
    if (busy !== 1'b0 || pc !== 16'h0002 || instruction_out !== last_word) begin
      failures++;
      $display("FAIL to_state busy=%b pc=%h ir=%h want 0/0002/%h", busy, pc, instruction_out,
               last_word);
    end
    checks++;
    if (ir_cnt != 0 || err_cnt != 1 || req_cycles != 15 || req_idle != 0) begin
      failures++;
      $display("FAIL to_counts ir=%0d err=%0d req=%0d ri=%0d want 0/1/15/0",
               ir_cnt, err_cnt, req_cycles, req_idle);
    end
  endtask

  task automatic test_pc_load();
    int n; bit ok; logic [15:0] e;
    clear_mon(); wait_cfg = 0;
    exp_q.push_back(word(16'h0040));
    pulse_fetch(1'b1, 16'h0040);
    wait_event(1'b0, n, ok);
    e = exp_q.size() ? exp_q.pop_front() : 16'hxxxx;
    checks++;
    if (!ok || instruction_out !== e || first_addr !== 16'h0040) begin
      failures++;
      $display("FAIL ld_idle_fetch ok=%0d ir=%h addr=%h want %h/0040", ok, instruction_out,
               first_addr, e);
    end
    @(negedge clk); #1;
    checks++;
    if (pc !== 16'h0041) begin
      failures++; $display("FAIL ld_idle_pc got=%h want=0041", pc);
    end
    // Second fetch from 0x41 with a load arriving during WRITE.
    clear_mon();
    exp_q.push_back(word(16'h0041));
    pulse_fetch(1'b0, 16'h0);
    wait_event(1'b0, n, ok);
    e = exp_q.size() ? exp_q.pop_front() : 16'hxxxx;
    last_word = e;
    checks++;
    if (!ok || instruction_out !== e || first_addr !== 16'h0041) begin
      failures++;
      $display("FAIL ld_write_fetch ok=%0d ir=%h addr=%h want %h/0041", ok, instruction_out,
               first_addr, e);
    end
    pc_ld_en = 1'b1; pc_ld_value = 16'h0100;
    @(posedge clk); #1;
    pc_ld_en = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (pc !== 16'h0100) begin
      failures++; $display("FAIL ld_write_pc got=%h want=0100", pc);
    end
  endtask

  task automatic test_wrap_held_req();
    int n; bit ok; logic [15:0] e;
    clear_mon(); wait_cfg = 2;
    exp_q.push_back(word(16'hFFFF));
    fetch_req = 1'b1; pc_ld_en = 1'b1; pc_ld_value = 16'hFFFF;
    @(posedge clk); #1;
    pc_ld_en = 1'b0;
    wait_event(1'b0, n, ok);
    fetch_req = 1'b0;
    e = exp_q.size() ? exp_q.pop_front() : 16'hxxxx;
    last_word = e;
    checks++;
    if (!ok || n != 4 || instruction_out !== e) begin
      failures++;
      $display("FAIL wrap_fetch ok=%0d n=%0d ir=%h want 4/%h", ok, n, instruction_out, e);
    end
    @(negedge clk); #1;
    checks++;
    if (pc !== 16'h0000 || first_addr !== 16'hFFFF || addr_unstable) begin
      failures++;
      $display("FAIL wrap_pc pc=%h addr=%h unst=%0d want 0000/ffff/0", pc, first_addr,
               addr_unstable);
    end
    checks++;
    if (ir_cnt != 1 || req_cycles != 3 || busy !== 1'b0) begin
      failures++;
      $display("FAIL held_req ir=%0d req=%0d busy=%b want 1/3/0", ir_cnt, req_cycles, busy);
    end
  endtask

  task automatic test_back_to_back();
    int n; bit ok; logic [15:0] e;
    clear_mon(); wait_cfg = 0;
    for (int k = 0; k < 3; k++) exp_q.push_back(word(16'(k)));
    fetch_req = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      wait_event(1'b0, n, ok);
      if (k == 2) fetch_req = 1'b0;
      e = exp_q.size() ? exp_q.pop_front() : 16'hxxxx;
      last_word = e;
      checks++;
      if (!ok || n != ((k == 0) ? 2 : 3) || instruction_out !== e) begin
        failures++;
        $display("FAIL b2b_%0d ok=%0d gap=%0d ir=%h want gap=%0d ir=%h", k, ok, n,
                 instruction_out, (k == 0) ? 2 : 3, e);
      end
    end
    @(negedge clk); #1;
    checks++;
    if (pc !== 16'h0003 || ir_cnt != 3 || busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_end pc=%h ir=%0d busy=%b want 0003/3/0", pc, ir_cnt, busy);
    end
  endtask

  task automatic test_reset_mid_fetch();
    clear_mon(); wait_cfg = 10;
    pulse_fetch(1'b0, 16'h0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({mem_req, ir_wr_en, fetch_done, fetch_err, busy} !== 5'b0 || instruction_out !== 16'h0 ||
        mem_addr !== 16'h0 || pc !== 16'h0) begin
      failures++;
      $display("FAIL rst_mid req=%b ir_wr=%b done=%b err=%b busy=%b ir=%h addr=%h pc=%h want all 0",
               mem_req, ir_wr_en, fetch_done, fetch_err, busy, instruction_out, mem_addr, pc);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    wait_cfg = 0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (pc !== 16'h0000 || ir_cnt != 0 || busy !== 1'b0 || req_cycles != 3) begin
      failures++;
      $display("FAIL rst_mid_after pc=%h ir=%0d busy=%b req=%0d want 0000/0/0/3",
               pc, ir_cnt, busy, req_cycles);
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait4();
    test_timeout();
    test_pc_load();
    test_wrap_held_req();
    test_back_to_back();
    test_reset_mid_fetch();
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL scoreboard_left got=%0d want=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
